// File: rtl/lock_servo_driver.sv
// Servo PWM driver for a lock actuator: ramps the pulse width between closed and open once per frame.
// Optional auto-relock after a dwell in OPEN is compiled in with `define LOCK_AUTO_RELOCK_EN.
module lock_servo_driver #(
  parameter int CLKS_PER_FRAME = 1000000,
  parameter int PW_CLOSED      = 50000,
  parameter int PW_OPEN        = 100000,
  parameter int PW_STEP        = 500,
  parameter int RELOCK_FRAMES  = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_open,
  output logic servo_pwm,
  output logic at_open,
  output logic at_closed,
  output logic moving
);

  localparam int CNT_W = $clog2(CLKS_PER_FRAME);
  localparam int PW_W  = $clog2(PW_OPEN + PW_STEP + 1);
  localparam int CMP_W = (CNT_W > PW_W) ? CNT_W : PW_W;

  localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(CLKS_PER_FRAME - 1);
  localparam logic [PW_W-1:0]  LP_CLOSED = PW_W'(PW_CLOSED);
  localparam logic [PW_W-1:0]  LP_OPEN   = PW_W'(PW_OPEN);
  localparam logic [PW_W-1:0]  LP_STEP   = PW_W'(PW_STEP);
  localparam logic [PW_W-1:0]  LP_DN_LIM = PW_W'(PW_CLOSED + PW_STEP);

  if (PW_CLOSED >= PW_OPEN || PW_OPEN >= CLKS_PER_FRAME || PW_STEP < 1 || RELOCK_FRAMES < 1)
  begin : g_bad_cfg
    $error("lock_servo_driver: invalid parameter set");
  end

  typedef enum logic [1:0] {ST_CLOSED, ST_OPENING, ST_OPEN, ST_CLOSING} state_t;

  state_t           r_state, w_state_nxt;
  logic [PW_W-1:0]  r_pw, w_pw_nxt, w_up;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pwm;
  logic             w_bnd, w_target, w_pwm_d;

  assign w_bnd   = (r_cnt == '0);
  assign w_up    = r_pw + LP_STEP;
  assign w_pwm_d = (CMP_W'(r_cnt) < CMP_W'(r_pw));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
      r_pwm <= w_pwm_d;
    end
  end

`ifdef LOCK_AUTO_RELOCK_EN
  localparam int RL_W = (RELOCK_FRAMES > 1) ? $clog2(RELOCK_FRAMES) : 1;
  localparam logic [RL_W-1:0] LP_RL_LAST = RL_W'(RELOCK_FRAMES - 1);

  logic [RL_W-1:0] r_relock_cnt;
  logic            r_forced, r_lock_d;

  // Forced-closed latch releases only on a fresh 0->1 of lock_open; a new force wins a same-cycle release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_relock_cnt <= '0;
      r_forced     <= 1'b0;
      r_lock_d     <= 1'b0;
    end else begin
      r_lock_d <= lock_open;
      if (lock_open && !r_lock_d) r_forced <= 1'b0;
      if (r_state != ST_OPEN) begin
        r_relock_cnt <= '0;
      end else if (w_bnd) begin
        if (r_relock_cnt == LP_RL_LAST) begin
          r_forced     <= 1'b1;
          r_relock_cnt <= '0;
        end else begin
          r_relock_cnt <= r_relock_cnt + 1'b1;
        end
      end
    end
  end

  assign w_target = lock_open & ~r_forced;
`else
  assign w_target = lock_open;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_CLOSED;
      r_pw    <= LP_CLOSED;
    end else begin
      r_state <= w_state_nxt;
      r_pw    <= w_pw_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pw_nxt    = r_pw;
    case (r_state)
      ST_CLOSED: if (w_target) w_state_nxt = ST_OPENING;
      ST_OPENING: begin
        if (!w_target) begin
          w_state_nxt = ST_CLOSING;
        end else if (w_bnd) begin
          if (w_up >= LP_OPEN) begin
            w_pw_nxt    = LP_OPEN;
            w_state_nxt = ST_OPEN;
          end else begin
            w_pw_nxt = w_up;
          end
        end
      end
      ST_OPEN: if (!w_target) w_state_nxt = ST_CLOSING;
      ST_CLOSING: begin
        if (w_target) begin
          w_state_nxt = ST_OPENING;
        end else if (w_bnd) begin
          if (r_pw <= LP_DN_LIM) begin
            w_pw_nxt    = LP_CLOSED;
            w_state_nxt = ST_CLOSED;
          end else begin
            w_pw_nxt = r_pw - LP_STEP;
          end
        end
      end
      default: w_state_nxt = ST_CLOSED;
    endcase
  end

  assign servo_pwm = r_pwm;
  assign at_open   = (r_state == ST_OPEN)   && (r_pw == LP_OPEN);
  assign at_closed = (r_state == ST_CLOSED) && (r_pw == LP_CLOSED);
  assign moving    = (r_state == ST_OPENING) || (r_state == ST_CLOSING);

endmodule

// File: tb/tb_lock_servo_driver.sv
// Self-checking bench for lock_servo_driver: vector table, hand sequences and random lock_open
// traffic against a direction/pulse-width reference model.
module tb_lock_servo_driver;

  localparam int N    = 40;
  localparam int PWC  = 10;
  localparam int PWO  = 30;
  localparam int STEP = 3;
  localparam int RF   = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lock_open = 1'b0;
  logic servo_pwm, at_open, at_closed, moving;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lock_servo_driver #(
    .CLKS_PER_FRAME(N),
    .PW_CLOSED(PWC),
    .PW_OPEN(PWO),
    .PW_STEP(STEP),
    .RELOCK_FRAMES(RF)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .lock_open(lock_open),
    .servo_pwm(servo_pwm),
    .at_open(at_open),
    .at_closed(at_closed),
    .moving(moving)
  );

  // Reference: pulse width plus ramp direction (0 resting, +1 up, -1 down).
  typedef struct {
    int cnt;
    int pw;
    int dir;
    bit pwm;
    int open_frames;
    bit forced;
    bit prev;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.cnt = 0; r.pw = PWC; r.dir = 0; r.pwm = 1'b0;
    r.open_frames = 0; r.forced = 1'b0; r.prev = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c, input bit lock);
    model_t n;
    bit tgt, bnd, resting_open;
    n = c;
    n.pwm = (c.cnt < c.pw);
    n.cnt = (c.cnt + 1) % N;
    bnd = (c.cnt == 0);
    resting_open = (c.dir == 0) && (c.pw == PWO);
    tgt = lock;
`ifdef LOCK_AUTO_RELOCK_EN
    tgt = lock && !c.forced;
    if (lock && !c.prev) n.forced = 1'b0;
    if (!resting_open) n.open_frames = 0;
    else if (bnd) begin
      if (c.open_frames + 1 >= RF) begin
        n.forced = 1'b1;
        n.open_frames = 0;
      end else n.open_frames = c.open_frames + 1;
    end
    n.prev = lock;
`endif
    if (c.dir == 0) begin
      if (tgt && c.pw == PWC) n.dir = 1;
      else if (!tgt && c.pw == PWO) n.dir = -1;
    end else if ((c.dir > 0) != tgt) begin
      n.dir = tgt ? 1 : -1;
    end else if (bnd) begin
      n.pw = c.pw + c.dir * STEP;
      if (n.pw >= PWO) begin n.pw = PWO; n.dir = 0; end
      else if (n.pw <= PWC) begin n.pw = PWC; n.dir = 0; end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, lock_open);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pwm", servo_pwm, m.pwm);
      check("model_at_open", at_open, (m.dir == 0 && m.pw == PWO));
      check("model_at_closed", at_closed, (m.dir == 0 && m.pw == PWC));
      check("model_moving", moving, (m.dir != 0));
    end
  end

  task automatic measure_frame(input string name, input int exp);
    int highs;
    highs = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (servo_pwm) highs++;
    end
    check(name, highs, exp);
  endtask

  typedef struct {
    bit lock;
    int cycles;
    bit e_open;
    bit e_closed;
    bit e_moving;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b1, 1,   1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 400, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1,   1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 400, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2,   1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1,   1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 400, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 120, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 400, 1'b0, 1'b1, 1'b0});

    repeat (3) @(negedge clk);
    check("rst_pwm", servo_pwm, 0);
    check("rst_at_closed", at_closed, 1);
    check("rst_at_open", at_open, 0);
    check("rst_moving", moving, 0);
    chk_en = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_pulse_after_reset", servo_pwm, 1);
    measure_frame("closed_width_frame1", PWC);
    measure_frame("closed_width_frame2", PWC);
    measure_frame("closed_width_frame3", PWC);

    foreach (vecs[i]) begin
      lock_open = vecs[i].lock;
      repeat (vecs[i].cycles) @(negedge clk);
      check($sformatf("vec%0d_at_open", i), at_open, vecs[i].e_open);
      check($sformatf("vec%0d_at_closed", i), at_closed, vecs[i].e_closed);
      check($sformatf("vec%0d_moving", i), moving, vecs[i].e_moving);
    end

    lock_open = 1'b1;
    repeat (400) @(negedge clk);
    measure_frame("open_width", PWO);
    lock_open = 1'b0;
    repeat (400) @(negedge clk);

    lock_open = 1'b1;
    repeat (2 * N + 15) @(negedge clk);
    check("pre_reset_moving", moving, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", servo_pwm, 0);
    check("async_rst_at_closed", at_closed, 1);
    check("async_rst_at_open", at_open, 0);
    check("async_rst_moving", moving, 0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_pulse_after_mid_reset", servo_pwm, 1);
    measure_frame("post_reset_width", PWC);

`ifndef LOCK_AUTO_RELOCK_EN
    begin
      int dropped;
      dropped = 0;
      repeat (8 * N) @(negedge clk);
      check("hold_open_reached", at_open, 1);
      for (int f = 0; f < 30; f++) begin
        repeat (N) @(negedge clk);
        if (!at_open) dropped++;
      end
      check("hold_open_frames_dropped", dropped, 0);
    end
`else
    begin
      int elapsed;
      bit seen;
      repeat (8 * N) @(negedge clk);
      check("relock_open_reached", at_open, 1);
      elapsed = 0;
      seen = 1'b0;
      for (int c = 0; c < (RF + 3) * N && !seen; c++) begin
        @(negedge clk);
        elapsed++;
        if (moving) seen = 1'b1;
      end
      check("relock_triggered", seen, 1);
      check("relock_dwell_in_range", (elapsed >= (RF - 8) * N && elapsed <= (RF + 1) * N), 1);
      repeat (10 * N) @(negedge clk);
      check("relock_closed", at_closed, 1);
      repeat (3 * N) @(negedge clk);
      check("relock_no_reopen", at_closed, 1);
      lock_open = 1'b0;
      repeat (2) @(negedge clk);
      lock_open = 1'b1;
      repeat (2) @(negedge clk);
      check("relock_reopen_after_toggle", moving, 1);
    end
`endif

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) lock_open = ~lock_open;
      if ($urandom_range(0, 199) == 0) begin
        lock_open = ~lock_open;
        @(negedge clk);
        lock_open = ~lock_open;
      end
      if ($urandom_range(0, 1499) == 0) begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lock_servo_driver.md
LOCK_SERVO_DRIVER -- requirements
Module: lock_servo_driver

Interface
REQ-001 SHALL have parameter CLKS_PER_FRAME, default 1000000, meaning servo frame length in clk cycles (20 ms at 50 MHz).
REQ-002 SHALL have parameter PW_CLOSED, default 50000, meaning pulse width in cycles for the closed position (1.0 ms).
REQ-003 SHALL have parameter PW_OPEN, default 100000, meaning pulse width in cycles for the open position (2.0 ms); PW_CLOSED < PW_OPEN < CLKS_PER_FRAME.
REQ-004 SHALL have parameter PW_STEP, default 500, meaning maximum pulse-width change per frame (ramp rate).
REQ-005 SHALL have parameter RELOCK_FRAMES, default 250, meaning open dwell in frames before auto-relock (5 s).
REQ-006 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 lock_open  input  1  requested state from the command decoder, same clock domain (1 open, 0 closed).
REQ-009 servo_pwm  output  1  registered servo pulse output.
REQ-010 at_open  output  1  high while the pulse width equals PW_OPEN and state is OPEN.
REQ-011 at_closed  output  1  high while the pulse width equals PW_CLOSED and state is CLOSED.
REQ-012 moving  output  1  high in OPENING or CLOSING.

Function
REQ-013 SHALL run a free-running frame counter 0..CLKS_PER_FRAME-1 that wraps to 0; the cycle with count 0 is the frame boundary.
REQ-014 SHALL drive servo_pwm registered: high when frame count < pw_cur, otherwise low; one clk latency from counter to pin.
REQ-015 SHALL change pw_cur only at a frame boundary, so no frame contains a truncated or double pulse.
REQ-016 SHALL implement states CLOSED, OPENING, OPEN, CLOSING.
REQ-017 CLOSED -> OPENING when the effective target is open; OPEN -> CLOSING when the effective target is closed; the transition is taken on the clk after the target changes.
REQ-018 In OPENING, at each frame boundary pw_cur SHALL increase by PW_STEP, clamped to PW_OPEN; on reaching PW_OPEN the state SHALL become OPEN.
REQ-019 In CLOSING, at each frame boundary pw_cur SHALL decrease by PW_STEP, clamped to PW_CLOSED; on reaching PW_CLOSED the state SHALL become CLOSED.
REQ-020 A target reversal mid-ramp SHALL switch OPENING<->CLOSING immediately, with the ramp continuing from the current pw_cur (no jump).
REQ-021 pw_cur width SHALL be sized so that pw_cur + PW_STEP does not overflow before clamping.
REQ-022 Target pulses shorter than one frame SHALL still start a ramp; the ramp reverses at the next boundary per REQ-020.

Reset
REQ-023 While rst is low: state CLOSED, pw_cur = PW_CLOSED, frame count 0, servo_pwm 0, at_closed 1, at_open 0, moving 0, relock counter 0.
REQ-024 Reset asserted mid-ramp SHALL snap immediately to the REQ-023 values, with no completion of the current frame.
REQ-025 After rst rises, the first servo_pwm high SHALL occur on the following clk, and the first frame SHALL start at count 0.

Configuration
REQ-026 Macro LOCK_AUTO_RELOCK_EN SHALL compile in auto-relock.
REQ-027 With the macro defined: the block SHALL count frame boundaries while in OPEN, and after RELOCK_FRAMES boundaries the effective target SHALL be forced closed (-> CLOSING) even if lock_open is still 1.
REQ-028 With the macro defined: after a forced relock, the effective target SHALL stay closed until lock_open is seen low and then high again (rising edge); the relock counter SHALL clear on leaving OPEN.
REQ-029 Without the macro: the effective target SHALL equal lock_open, no relock counter SHALL exist, and OPEN SHALL be held indefinitely.

Verification
REQ-030 Reset then idle 3 frames -> servo_pwm high exactly 50000 cycles per 1000000, at_closed=1, moving=0.
REQ-031 lock_open 0->1 -> moving=1 on the next clk; width grows by 500 per frame; at_open=1 after 100 frames; width then 100000.
REQ-032 lock_open 1->0 after 40 frames of OPENING (pw 70000) -> CLOSING; next frame 69500; at_closed after 40 more frames.
REQ-033 rst low for 10 cycles mid-frame during OPENING -> all outputs at REQ-023 values asynchronously; first post-reset pulse 50000 cycles.
REQ-034 With LOCK_AUTO_RELOCK_EN and lock_open held 1 -> OPEN, then CLOSING after 250 frames, at_closed after 100 more frames; no reopen until lock_open toggles 0->1.
REQ-035 Without the macro, same stimulus as REQ-034 -> at_open remains 1 for 1000 frames.
